// File: rtl/ex_to_id_bypass.sv
// rtl/ex_to_id_bypass.sv - EX-to-WB return stage with operand forwarding to ID and late-result stall
module ex_to_id_bypass #(
    parameter int DATA_W      = 16,
    parameter int ADRS_W      = 4,
    parameter int ZERO_REG_EN = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADRS_W-1:0] id_src1,
    input  logic [ADRS_W-1:0] id_src2,
    input  logic              id_src1_used,
    input  logic              id_src2_used,
    input  logic [DATA_W-1:0] id_dat1,
    input  logic [DATA_W-1:0] id_dat2,
    input  logic              ex_wr_en,
    input  logic [ADRS_W-1:0] ex_dst,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_late,
    input  logic [DATA_W-1:0] late_data,
    output logic [DATA_W-1:0] fwd_dat1,
    output logic [DATA_W-1:0] fwd_dat2,
    output logic              stall,
    output logic              wb_wr_en,
    output logic [ADRS_W-1:0] wb_dst,
    output logic [DATA_W-1:0] wb_data,
    output logic [15:0]       stall_count
);

    logic              wb_wr_q;
    logic [ADRS_W-1:0] wb_dst_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              wb_late_q;
    logic [15:0]       stall_count_q;

    logic hit_ex1, hit_ex2, hit_wb1, hit_wb2;

    // Address 0 is the hard-wired zero register when enabled: never written, never matched.
    function automatic logic is_zero_reg(input logic [ADRS_W-1:0] a);
        return (ZERO_REG_EN != 0) && (a == '0);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            wb_wr_q       <= 1'b0;
            wb_dst_q      <= '0;
            wb_data_q     <= '0;
            wb_late_q     <= 1'b0;
            stall_count_q <= '0;
        end else begin
            wb_wr_q   <= ex_wr_en && !is_zero_reg(ex_dst);
            wb_dst_q  <= ex_dst;
            wb_data_q <= ex_result;
            wb_late_q <= ex_late;
            if (stall && (stall_count_q != 16'hFFFF)) begin
                stall_count_q <= stall_count_q + 16'd1;
            end
        end
    end

    assign wb_wr_en    = wb_wr_q;
    assign wb_dst      = wb_dst_q;
    assign wb_data     = wb_late_q ? late_data : wb_data_q;
    assign stall_count = stall_count_q;

    always_comb begin
        hit_ex1 = id_src1_used && ex_wr_en && (ex_dst == id_src1) && !is_zero_reg(id_src1);
        hit_ex2 = id_src2_used && ex_wr_en && (ex_dst == id_src2) && !is_zero_reg(id_src2);
        hit_wb1 = id_src1_used && wb_wr_q && (wb_dst_q == id_src1) && !is_zero_reg(id_src1);
        hit_wb2 = id_src2_used && wb_wr_q && (wb_dst_q == id_src2) && !is_zero_reg(id_src2);
    end

    // Youngest producer wins; a late EX hit stalls, so its operand value is irrelevant.
    always_comb begin
        fwd_dat1 = id_dat1;
        fwd_dat2 = id_dat2;
        stall    = 1'b0;
        if (!reset) begin
            if (hit_ex1 && !ex_late) begin
                fwd_dat1 = ex_result;
            end else if (hit_wb1) begin
                fwd_dat1 = wb_data;
            end
            if (hit_ex2 && !ex_late) begin
                fwd_dat2 = ex_result;
            end else if (hit_wb2) begin
                fwd_dat2 = wb_data;
            end
            stall = (hit_ex1 || hit_ex2) && ex_late;
        end
    end

endmodule
